// File: rtl/mem_access_pkg.sv
// Shared types for the data-memory access unit: FSM states, request/response codes,
// and helpers for the byte-alignment check and store lane selection.
package mem_access_pkg;

    localparam int WORD_BYTES = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        RESP  = 2'd3
    } state_e;

    typedef enum logic {
        OP_LOAD  = 1'b0,
        OP_STORE = 1'b1
    } op_e;

    typedef enum logic [1:0] {
        SZ_BYTE   = 2'd0,
        SZ_HALF   = 2'd1,
        SZ_WORD   = 2'd2,
        SZ_DOUBLE = 2'd3
    } size_e;

    typedef enum logic [1:0] {
        EXC_NONE        = 2'd0,
        EXC_MISALIGNED  = 2'd1,
        EXC_LOAD_FAULT  = 2'd2,
        EXC_STORE_FAULT = 2'd3
    } exc_e;

    // Offset bits that must be zero for an access of this size.
    function automatic logic [2:0] align_mask(input size_e size);
        logic [2:0] m;
        case (size)
            SZ_BYTE: m = 3'b000;
            SZ_HALF: m = 3'b001;
            SZ_WORD: m = 3'b011;
            default: m = 3'b111;
        endcase
        return m;
    endfunction

    function automatic logic [WORD_BYTES-1:0] lane_mask(input size_e size, input logic [2:0] off);
        logic [WORD_BYTES-1:0] m;
        case (size)
            SZ_BYTE: m = 8'h01;
            SZ_HALF: m = 8'h03;
            SZ_WORD: m = 8'h0F;
            default: m = 8'hFF;
        endcase
        return m << off;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational byte-lane steering: extracts and extends load data from a 64-bit word,
// and merges right-justified store data into the enclosing word.
module mem_lane_align
    import mem_access_pkg::*;
(
    input  logic [63:0] word_i,
    input  logic [2:0]  offset_i,
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    input  logic [63:0] store_data_i,
    output logic [63:0] load_data_o,
    output logic [63:0] merged_o
);
    logic [63:0]           shifted;
    logic [63:0]           store_shifted;
    logic [WORD_BYTES-1:0] lanes;

    assign shifted       = word_i >> {offset_i, 3'b000};
    assign store_shifted = store_data_i << {offset_i, 3'b000};
    assign lanes         = lane_mask(size_e'(size_i), offset_i);

    always_comb begin
        load_data_o = shifted;
        case (size_e'(size_i))
            SZ_BYTE: load_data_o = unsigned_i ? {56'h0, shifted[7:0]}
                                              : {{56{shifted[7]}}, shifted[7:0]};
            SZ_HALF: load_data_o = unsigned_i ? {48'h0, shifted[15:0]}
                                              : {{48{shifted[15]}}, shifted[15:0]};
            SZ_WORD: load_data_o = unsigned_i ? {32'h0, shifted[31:0]}
                                              : {{32{shifted[31]}}, shifted[31:0]};
            default: load_data_o = shifted;
        endcase
    end

    for (genvar b = 0; b < WORD_BYTES; b++) begin : g_merge
        assign merged_o[b*8 +: 8] = lanes[b] ? store_shifted[b*8 +: 8] : word_i[b*8 +: 8];
    end

endmodule

// File: rtl/mem_access_unit.sv
// Single-outstanding load/store initiator; sub-word stores are read-modify-write.
// Load response in cycle 2, store in cycle 3, misaligned in cycle 1; response held until in_resp_ready.
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int MEM_ADDR_WIDTH = 64,
    parameter int DATA_WIDTH     = 64
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_req_valid,
    output logic                      out_req_ready,
    input  logic                      in_req_op,
    input  logic [1:0]                in_req_size,
    input  logic                      in_req_unsigned,
    input  logic [MEM_ADDR_WIDTH-1:0] in_req_address,
    input  logic [DATA_WIDTH-1:0]     in_req_data,
    output logic                      out_resp_valid,
    input  logic                      in_resp_ready,
    output logic [DATA_WIDTH-1:0]     out_resp_data,
    output logic [1:0]                out_resp_exception,
    output logic [MEM_ADDR_WIDTH-1:0] out_mem_read_address,
    input  logic [DATA_WIDTH-1:0]     in_mem_read_data,
    input  logic                      in_mem_read_exception,
    output logic                      out_mem_write_enable,
    output logic [MEM_ADDR_WIDTH-1:0] out_mem_write_address,
    output logic [DATA_WIDTH-1:0]     out_mem_write_data,
    input  logic                      in_mem_write_exception
);
    state_e                    state_q, state_d;
    op_e                       op_q;
    size_e                     size_q;
    logic                      uns_q;
    logic [2:0]                off_q;
    logic [MEM_ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0]     wdata_q, word_q;
    logic [DATA_WIDTH-1:0]     rdata_q, rdata_d;
    exc_e                      exc_q, exc_d;

    logic                  accept;
    logic                  misaligned;
    logic [DATA_WIDTH-1:0] lane_word, load_val, merged_word;

    assign accept     = (state_q == IDLE) && in_req_valid;
    assign misaligned = (in_req_address[2:0] & align_mask(size_e'(in_req_size))) != 3'b000;
    // Extraction works on the live read data; the merge works on the word captured in READ.
    assign lane_word  = (state_q == READ) ? in_mem_read_data : word_q;

    mem_lane_align u_lane_align (
        .word_i       (lane_word),
        .offset_i     (off_q),
        .size_i       (size_q),
        .unsigned_i   (uns_q),
        .store_data_i (wdata_q),
        .load_data_o  (load_val),
        .merged_o     (merged_word)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        exc_d   = exc_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: begin
                if (in_req_valid) begin
                    rdata_d = '0;
                    if (misaligned) begin
                        state_d = RESP;
                        exc_d   = EXC_MISALIGNED;
                    end else begin
                        state_d = READ;
                        exc_d   = EXC_NONE;
                    end
                end
            end
            READ: begin
                if (in_mem_read_exception) begin
                    state_d = RESP;
                    if (op_q == OP_STORE) exc_d = EXC_STORE_FAULT;
                    else                  exc_d = EXC_LOAD_FAULT;
                end else if (op_q == OP_STORE) begin
                    state_d = WRITE;
                end else begin
                    state_d = RESP;
                    rdata_d = load_val;
                end
            end
            WRITE: begin
                state_d = RESP;
                if (in_mem_write_exception) exc_d = EXC_STORE_FAULT;
                else                        exc_d = EXC_NONE;
            end
            RESP: begin
                if (in_resp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        out_req_ready         = (state_q == IDLE);
        out_resp_valid        = (state_q == RESP);
        out_resp_data         = '0;
        out_resp_exception    = 2'd0;
        out_mem_read_address  = '0;
        out_mem_write_enable  = 1'b0;
        out_mem_write_address = '0;
        out_mem_write_data    = '0;
        if (state_q == RESP) begin
            out_resp_data      = rdata_q;
            out_resp_exception = exc_q;
        end
        if (state_q == READ) begin
            out_mem_read_address = addr_q;
        end
        if (state_q == WRITE) begin
            out_mem_write_enable  = !in_mem_write_exception;
            out_mem_write_address = addr_q;
            out_mem_write_data    = merged_word;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_q    <= OP_LOAD;
            size_q  <= SZ_BYTE;
            uns_q   <= 1'b0;
            off_q   <= 3'b000;
            addr_q  <= '0;
            wdata_q <= '0;
            word_q  <= '0;
            rdata_q <= '0;
            exc_q   <= EXC_NONE;
        end else begin
            rdata_q <= rdata_d;
            exc_q   <= exc_d;
            if (accept) begin
                op_q    <= op_e'(in_req_op);
                size_q  <= size_e'(in_req_size);
                uns_q   <= in_req_unsigned;
                off_q   <= in_req_address[2:0];
                addr_q  <= {in_req_address[MEM_ADDR_WIDTH-1:3], 3'b000};
                wdata_q <= in_req_data;
            end
            if (state_q == READ) begin
                word_q <= in_mem_read_data;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: behavioural 64-bit memory, scoreboard of expected responses,
// one task per scenario with inline comparisons.
module tb_mem_access_unit;

    localparam logic [63:0] PRE = 64'h8877_6655_4433_2211;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_req_valid = 1'b0;
    logic        out_req_ready;
    logic        in_req_op = 1'b0;
    logic [1:0]  in_req_size = 2'd0;
    logic        in_req_unsigned = 1'b0;
    logic [63:0] in_req_address = 64'h0;
    logic [63:0] in_req_data = 64'h0;
    logic        out_resp_valid;
    logic        in_resp_ready = 1'b1;
    logic [63:0] out_resp_data;
    logic [1:0]  out_resp_exception;
    logic [63:0] out_mem_read_address;
    logic [63:0] in_mem_read_data;
    logic        in_mem_read_exception;
    logic        out_mem_write_enable;
    logic [63:0] out_mem_write_address;
    logic [63:0] out_mem_write_data;
    logic        in_mem_write_exception;

    always #5 clk = ~clk;

    mem_access_unit dut (
        .clk                    (clk),
        .reset                  (reset),
        .in_req_valid           (in_req_valid),
        .out_req_ready          (out_req_ready),
        .in_req_op              (in_req_op),
        .in_req_size            (in_req_size),
        .in_req_unsigned        (in_req_unsigned),
        .in_req_address         (in_req_address),
        .in_req_data            (in_req_data),
        .out_resp_valid         (out_resp_valid),
        .in_resp_ready          (in_resp_ready),
        .out_resp_data          (out_resp_data),
        .out_resp_exception     (out_resp_exception),
        .out_mem_read_address   (out_mem_read_address),
        .in_mem_read_data       (in_mem_read_data),
        .in_mem_read_exception  (in_mem_read_exception),
        .out_mem_write_enable   (out_mem_write_enable),
        .out_mem_write_address  (out_mem_write_address),
        .out_mem_write_data     (out_mem_write_data),
        .in_mem_write_exception (in_mem_write_exception)
    );

    // Behavioural memory: 64 words, combinational read, write on the rising edge.
    logic [63:0] mem [0:63];
    logic        preload = 1'b0;
    logic        force_rd_exc = 1'b0;
    logic        force_wr_exc = 1'b0;

    assign in_mem_read_data       = mem[out_mem_read_address[8:3]];
    assign in_mem_read_exception  = force_rd_exc;
    assign in_mem_write_exception = force_wr_exc;

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 64; i++) mem[i] <= 64'h0;
            mem[32] <= PRE;
        end else if (out_mem_write_enable) begin
            mem[out_mem_write_address[8:3]] <= out_mem_write_data;
        end
    end

    typedef struct {
        logic [63:0] data;
        logic [1:0]  exc;
    } exp_t;

    exp_t sb_q[$];
    exp_t e;

    int n_checks = 0;
    int n_fail   = 0;

    // Observations gathered while a request is in flight.
    int          lat;
    int          we_cnt;
    int          we_cyc;
    logic [63:0] we_addr;
    logic [63:0] we_data;
    logic [63:0] rd_addr_c1;
    logic        rd_seen;
    logic [63:0] r_data;
    logic [1:0]  r_exc;
    logic        post_ready;

    logic [1:0]  ld_size [6] = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3};
    logic        ld_uns  [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [63:0] ld_addr [6] = '{64'h107, 64'h106, 64'h106, 64'h104, 64'h100, 64'h100};
    logic [63:0] ld_exp  [6] = '{64'hFFFF_FFFF_FFFF_FF88, 64'h0000_0000_0000_8877,
                                 64'hFFFF_FFFF_FFFF_8877, 64'hFFFF_FFFF_8877_6655,
                                 64'h0000_0000_4433_2211, PRE};

    task automatic preload_mem();
        @(negedge clk);
        preload = 1'b1;
        @(negedge clk);
        preload = 1'b0;
    endtask

    // Drives one request for a single accept edge; returns #1 after that edge (cycle 1).
    task automatic issue(input logic op, input logic [1:0] size, input logic uns,
                         input logic [63:0] addr, input logic [63:0] wdata,
                         input logic [63:0] exp_data, input logic [1:0] exp_exc);
        exp_t x;
        @(negedge clk);
        in_req_valid    = 1'b1;
        in_req_op       = op;
        in_req_size     = size;
        in_req_unsigned = uns;
        in_req_address  = addr;
        in_req_data     = wdata;
        x.data = exp_data;
        x.exc  = exp_exc;
        sb_q.push_back(x);
        @(posedge clk);
        #1;
        in_req_valid = 1'b0;
    endtask

    // Watches cycles 1.. until out_resp_valid; steps past the response when ready is high.
    task automatic collect();
        lat        = 1;
        we_cnt     = 0;
        we_cyc     = 0;
        we_addr    = 64'h0;
        we_data    = 64'h0;
        rd_seen    = 1'b0;
        rd_addr_c1 = out_mem_read_address;
        post_ready = 1'b0;
        while (1) begin
            if (out_mem_read_address != 64'h0) rd_seen = 1'b1;
            if (out_mem_write_enable) begin
                we_cnt++;
                we_cyc  = lat;
                we_addr = out_mem_write_address;
                we_data = out_mem_write_data;
            end
            if (out_resp_valid) break;
            if (lat >= 20) begin
                n_checks++;
                n_fail++;
                $display("FAIL resp_timeout: no out_resp_valid within %0d cycles", lat);
                break;
            end
            @(posedge clk);
            #1;
            lat++;
        end
        r_data = out_resp_data;
        r_exc  = out_resp_exception;
        if (in_resp_ready) begin
            @(posedge clk);
            #1;
            post_ready = out_req_ready;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #2;
        reset = 1'b0;
        preload_mem();
        #1;
        n_checks++; if (out_req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_req_ready got %b want 1", out_req_ready); end
        n_checks++; if (out_resp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_resp_valid got %b want 0", out_resp_valid); end
        n_checks++; if (out_mem_write_enable !== 1'b0) begin n_fail++; $display("FAIL rst_we got %b want 0", out_mem_write_enable); end
        n_checks++; if (out_resp_data !== 64'h0) begin n_fail++; $display("FAIL rst_resp_data got %h want 0", out_resp_data); end
        n_checks++; if (out_resp_exception !== 2'd0) begin n_fail++; $display("FAIL rst_resp_exc got %0d want 0", out_resp_exception); end
        n_checks++; if (out_mem_read_address !== 64'h0) begin n_fail++; $display("FAIL rst_rd_addr got %h want 0", out_mem_read_address); end
        n_checks++; if (out_mem_write_address !== 64'h0) begin n_fail++; $display("FAIL rst_wr_addr got %h want 0", out_mem_write_address); end
        n_checks++; if (out_mem_write_data !== 64'h0) begin n_fail++; $display("FAIL rst_wr_data got %h want 0", out_mem_write_data); end
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        n_checks++; if (out_req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_release_ready got %b want 1", out_req_ready); end
    endtask

    task automatic test_loads();
        for (int i = 0; i < 6; i++) begin
            issue(1'b0, ld_size[i], ld_uns[i], ld_addr[i], 64'hFFFF_FFFF_FFFF_FFFF, ld_exp[i], 2'd0);
            collect();
            e = sb_q.pop_front();
            n_checks++; if (rd_addr_c1 !== 64'h100) begin n_fail++; $display("FAIL load[%0d] rd_addr got %h want 100", i, rd_addr_c1); end
            n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL load[%0d] latency got %0d want 2", i, lat); end
            n_checks++; if (r_data !== e.data) begin n_fail++; $display("FAIL load[%0d] data got %h want %h", i, r_data, e.data); end
            n_checks++; if (r_exc !== e.exc) begin n_fail++; $display("FAIL load[%0d] exc got %0d want %0d", i, r_exc, e.exc); end
            n_checks++; if (we_cnt !== 0) begin n_fail++; $display("FAIL load[%0d] write_enables got %0d want 0", i, we_cnt); end
            n_checks++; if (post_ready !== 1'b1) begin n_fail++; $display("FAIL load[%0d] ready_after got %b want 1", i, post_ready); end
        end
    endtask

    task automatic test_store_half();
        preload_mem();
        issue(1'b1, 2'd1, 1'b0, 64'h102, 64'hDEAD_0000_0000_BEEF, 64'h0, 2'd0);
        collect();
        e = sb_q.pop_front();
        n_checks++; if (we_cnt !== 1) begin n_fail++; $display("FAIL sh we_count got %0d want 1", we_cnt); end
        n_checks++; if (we_cyc !== 2) begin n_fail++; $display("FAIL sh we_cycle got %0d want 2", we_cyc); end
        n_checks++; if (we_addr !== 64'h100) begin n_fail++; $display("FAIL sh we_addr got %h want 100", we_addr); end
        n_checks++; if (we_data !== 64'h8877_6655_BEEF_2211) begin n_fail++; $display("FAIL sh we_data got %h want 88776655beef2211", we_data); end
        n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL sh latency got %0d want 3", lat); end
        n_checks++; if (r_exc !== e.exc) begin n_fail++; $display("FAIL sh exc got %0d want %0d", r_exc, e.exc); end
        n_checks++; if (r_data !== e.data) begin n_fail++; $display("FAIL sh data got %h want %h", r_data, e.data); end
        issue(1'b0, 2'd3, 1'b0, 64'h100, 64'h0, 64'h8877_6655_BEEF_2211, 2'd0);
        collect();
        e = sb_q.pop_front();
        n_checks++; if (r_data !== e.data) begin n_fail++; $display("FAIL sh_readback data got %h want %h", r_data, e.data); end
    endtask

    task automatic test_misaligned();
        preload_mem();
        issue(1'b0, 2'd2, 1'b0, 64'h102, 64'h0, 64'h0, 2'd1);
        collect();
        e = sb_q.pop_front();
        n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL mis_lw latency got %0d want 1", lat); end
        n_checks++; if (r_exc !== e.exc) begin n_fail++; $display("FAIL mis_lw exc got %0d want %0d", r_exc, e.exc); end
        n_checks++; if (r_data !== e.data) begin n_fail++; $display("FAIL mis_lw data got %h want %h", r_data, e.data); end
        n_checks++; if (rd_seen !== 1'b0) begin n_fail++; $display("FAIL mis_lw read_activity got %b want 0", rd_seen); end
        issue(1'b1, 2'd3, 1'b0, 64'h104, 64'h1234, 64'h0, 2'd1);
        collect();
        e = sb_q.pop_front();
        n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL mis_sd latency got %0d want 1", lat); end
        n_checks++; if (r_exc !== e.exc) begin n_fail++; $display("FAIL mis_sd exc got %0d want %0d", r_exc, e.exc); end
        n_checks++; if (we_cnt !== 0) begin n_fail++; $display("FAIL mis_sd write_enables got %0d want 0", we_cnt); end
        n_checks++; if (mem[32] !== PRE) begin n_fail++; $display("FAIL mis_sd mem got %h want %h", mem[32], PRE); end
    endtask

    task automatic test_read_fault();
        preload_mem();
        force_rd_exc = 1'b1;
        issue(1'b1, 2'd1, 1'b0, 64'h100, 64'hCAFE, 64'h0, 2'd3);
        collect();
        e = sb_q.pop_front();
        n_checks++; if (r_exc !== e.exc) begin n_fail++; $display("FAIL rdf_store exc got %0d want %0d", r_exc, e.exc); end
        n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL rdf_store latency got %0d want 2", lat); end
        n_checks++; if (we_cnt !== 0) begin n_fail++; $display("FAIL rdf_store write_enables got %0d want 0", we_cnt); end
        issue(1'b0, 2'd0, 1'b0, 64'h107, 64'h0, 64'h0, 2'd2);
        collect();
        e = sb_q.pop_front();
        n_checks++; if (r_exc !== e.exc) begin n_fail++; $display("FAIL rdf_load exc got %0d want %0d", r_exc, e.exc); end
        n_checks++; if (r_data !== e.data) begin n_fail++; $display("FAIL rdf_load data got %h want %h", r_data, e.data); end
        force_rd_exc = 1'b0;
        n_checks++; if (mem[32] !== PRE) begin n_fail++; $display("FAIL rdf mem got %h want %h", mem[32], PRE); end
    endtask

    task automatic test_write_fault();
        preload_mem();
        force_wr_exc = 1'b1;
        issue(1'b1, 2'd2, 1'b0, 64'h104, 64'h1234_5678, 64'h0, 2'd3);
        collect();
        e = sb_q.pop_front();
        force_wr_exc = 1'b0;
        n_checks++; if (r_exc !== e.exc) begin n_fail++; $display("FAIL wrf exc got %0d want %0d", r_exc, e.exc); end
        n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL wrf latency got %0d want 3", lat); end
        n_checks++; if (we_cnt !== 0) begin n_fail++; $display("FAIL wrf write_enables got %0d want 0", we_cnt); end
        n_checks++; if (mem[32] !== PRE) begin n_fail++; $display("FAIL wrf mem got %h want %h", mem[32], PRE); end
    endtask

    task automatic test_backpressure();
        preload_mem();
        in_resp_ready = 1'b0;
        issue(1'b0, 2'd0, 1'b1, 64'h105, 64'h0, 64'h66, 2'd0);
        collect();
        e = sb_q.pop_front();
        n_checks++; if (r_data !== e.data) begin n_fail++; $display("FAIL bp data got %h want %h", r_data, e.data); end
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            n_checks++; if (out_resp_valid !== 1'b1) begin n_fail++; $display("FAIL bp[%0d] resp_valid got %b want 1", c, out_resp_valid); end
            n_checks++; if (out_resp_data !== e.data) begin n_fail++; $display("FAIL bp[%0d] resp_data got %h want %h", c, out_resp_data, e.data); end
            n_checks++; if (out_req_ready !== 1'b0) begin n_fail++; $display("FAIL bp[%0d] req_ready got %b want 0", c, out_req_ready); end
        end
        @(negedge clk);
        in_resp_ready = 1'b1;
        @(posedge clk);
        #1;
        n_checks++; if (out_resp_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release resp_valid got %b want 0", out_resp_valid); end
        n_checks++; if (out_req_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release req_ready got %b want 1", out_req_ready); end
    endtask

    task automatic test_back_to_back();
        preload_mem();
        issue(1'b1, 2'd0, 1'b0, 64'h107, 64'h1234_56AA, 64'h0, 2'd0);
        collect();
        e = sb_q.pop_front();
        n_checks++; if (we_data !== 64'hAA77_6655_4433_2211) begin n_fail++; $display("FAIL b2b_sb we_data got %h want aa77665544332211", we_data); end
        n_checks++; if (post_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_sb ready_after got %b want 1", post_ready); end
        issue(1'b0, 2'd3, 1'b0, 64'h100, 64'h0, 64'hAA77_6655_4433_2211, 2'd0);
        collect();
        e = sb_q.pop_front();
        n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL b2b_ld latency got %0d want 2", lat); end
        n_checks++; if (r_data !== e.data) begin n_fail++; $display("FAIL b2b_ld data got %h want %h", r_data, e.data); end
    endtask

    task automatic test_reset_mid_write();
        preload_mem();
        issue(1'b1, 2'd0, 1'b0, 64'h100, 64'h55, 64'h0, 2'd0);
        @(posedge clk);
        #1;
        n_checks++; if (out_mem_write_enable !== 1'b1) begin n_fail++; $display("FAIL rmw we_before_reset got %b want 1", out_mem_write_enable); end
        #2;
        reset = 1'b0;
        #1;
        n_checks++; if (out_mem_write_enable !== 1'b0) begin n_fail++; $display("FAIL rmw we_in_reset got %b want 0", out_mem_write_enable); end
        n_checks++; if (out_req_ready !== 1'b1) begin n_fail++; $display("FAIL rmw ready_in_reset got %b want 1", out_req_ready); end
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        sb_q.delete();
        @(posedge clk);
        #1;
        n_checks++; if (mem[32] !== PRE) begin n_fail++; $display("FAIL rmw mem got %h want %h", mem[32], PRE); end
        n_checks++; if (out_req_ready !== 1'b1) begin n_fail++; $display("FAIL rmw ready_after got %b want 1", out_req_ready); end
        n_checks++; if (out_resp_valid !== 1'b0) begin n_fail++; $display("FAIL rmw resp_valid_after got %b want 0", out_resp_valid); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_loads();
        test_store_half();
        test_misaligned();
        test_read_fault();
        test_write_fault();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_write();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Core-side initiator for the 64-bit data memory. Accepts one load or store at a time from the execute stage and drives the memory's read and write ports. Sub-word stores are done as read-modify-write of the enclosing aligned 64-bit word. Returns load data (sign- or zero-extended) or an exception code through a valid/ready response channel.

## Interface

- MEM_ADDR_WIDTH, 64: width of every address port.
- DATA_WIDTH, 64: memory word width; fixed at 64, and no other value is supported.
- clk  in  1  sole clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_req_valid  in  1  request present.
- out_req_ready  out  1  unit idle; the request is accepted when valid and ready are both high.
- in_req_op  in  1  0 = LOAD, 1 = STORE.
- in_req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = double.
- in_req_unsigned  in  1  loads only: zero-extend instead of sign-extend.
- in_req_address  in  64  byte address.
- in_req_data  in  64  store data, right-justified.
- out_resp_valid  out  1  response present.
- in_resp_ready  in  1  consumer takes the response.
- out_resp_data  out  64  extended load data; 0 for stores and for exceptions.
- out_resp_exception  out  2  0 = none, 1 = misaligned, 2 = load/read access fault, 3 = store access fault.
- out_mem_read_address  out  64  aligned word address (addr & ~7).
- in_mem_read_data  in  64  combinational read data from memory.
- in_mem_read_exception  in  1  combinational read fault for out_mem_read_address.
- out_mem_write_enable  out  1  write strobe; memory commits on the rising edge.
- out_mem_write_address  out  64  aligned word address.
- out_mem_write_data  out  64  merged full word.
- in_mem_write_exception  in  1  combinational write fault for out_mem_write_address.

## Operation

- FSM states:
  - IDLE: out_req_ready = 1.
  - READ: drives out_mem_read_address from the registered aligned address.
  - WRITE: stores only; drives the write port.
  - RESP: out_resp_valid = 1.
- On accept, register op, size, unsigned flag, byte offset (addr[2:0]), aligned address and store data.
- Alignment check at accept: misaligned if addr mod (1 << size) ≠ 0.
  - Misaligned requests go IDLE→RESP with code 1.
  - No memory port is driven for them.
- READ:
  - If in_mem_read_exception is high: go to RESP with code 2 (load) or 3 (store). No write is issued.
  - Otherwise capture in_mem_read_data. A load goes to RESP; a store goes to WRITE.
- Load extract: shift the captured word right by offset×8, keep the low 8<<size bits, then sign- or zero-extend. Double is passed through unchanged.
- Store merge: replace bytes [offset, offset + 2^size) of the captured word with the low bytes of the store data. All other bytes are preserved.
- WRITE:
  - out_mem_write_enable = !in_mem_write_exception, asserted for exactly one cycle.
  - Next state is RESP, with code 3 if the write faulted, else 0.
- RESP holds data and code stable until in_resp_ready is high, then returns to IDLE.
- No new request is accepted in the RESP exit cycle.
- Reset values:
  - out_req_ready = 1 (state IDLE).
  - out_resp_valid = 0, out_mem_write_enable = 0.
  - out_resp_data = 0, out_resp_exception = 0.
  - Address and write-data outputs = 0.
- Reset asserted mid-operation: immediate return to IDLE and write_enable drops asynchronously, so an in-flight WRITE is not committed. A pending response is discarded.

## Timing

- The accept edge is cycle 0.
- Load: READ in cycle 1; out_resp_valid in cycle 2.
- Store: READ in cycle 1; WRITE in cycle 2 (memory updated at the end of cycle 2); out_resp_valid in cycle 3.
- Misaligned: out_resp_valid in cycle 1.
- Throughput is at most one request per 3 cycles (load) or 4 cycles (store) with in_resp_ready held high.
- out_req_ready is a pure decode of state, with no combinational path from in_req_valid.
- The write exception is combinational through to write_enable.

## Structure

- Package mem_access_pkg contains:
  - state enum {IDLE, READ, WRITE, RESP}
  - op, size and exception-code enums
  - constant WORD_BYTES = 8
- Sub-module mem_lane_align is purely combinational. It takes the word, offset, size, unsigned flag and store data, and produces the extracted load value and the merged store word. It is instantiated once.

## Test plan

Memory preload for all cases: word 0x100 = 0x8877665544332211.

- Load byte, signed, at 0x107 → out_mem_read_address 0x100; in cycle 2, resp_data 0xFFFFFFFFFFFFFF88, code 0.
- Load half, unsigned, at 0x106 → resp_data 0x0000000000008877.
- Store half 0xBEEF at 0x102 → in cycle 2, write_enable = 1, addr 0x100, data 0x88776655BEEF2211; in cycle 3, resp code 0. A following double load returns the same value.
- Load word at 0x102 → in cycle 1, resp code 1. No read or write address activity.
- Store with in_mem_read_exception forced high → code 3, write_enable never asserted.
- Store with in_mem_write_exception forced high → code 3, memory unchanged.
- in_resp_ready held low for 5 cycles → resp_valid and resp_data stable throughout and out_req_ready = 0; the response completes on the first ready cycle.
- reset driven low during the store WRITE cycle → write_enable falls immediately, memory unchanged; after release, state is IDLE and out_req_ready = 1.
